gate_sweep_checker: RTL

- Synthesizable response-side companion to our small combinational gate blocks. Our simulation benches drive input patterns and print the output.
- This block drives every input combination onto a gate under test (GUT), waits a settle interval, samples the GUT output and compares it against a parameterised expected truth table.
- Reports pass/fail, error count and first failing vector. It runs on-chip or in a bench without $monitor.

---
 rtl/gate_sweep_checker_pkg.sv | 20 ++
 rtl/gate_sweep_checker_if.sv | 30 +++
 rtl/gate_sweep_checker_settle_timer.sv | 33 +++
 rtl/gate_sweep_checker.sv | 130 +++++++++++++
 4 files changed

// File: rtl/gate_sweep_checker_pkg.sv
// Shared types and constants for the gate sweep checker.
//   state_t   : sweep FSM encoding
//   CNT_W     : settle counter width (settle interval up to 15 cycles)
//   vec_count : number of input vectors for an n-input gate
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int CNT_W = 4;

  function automatic int vec_count(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Bus between the sweep checker and its gate under test / controller.
//   start      : one-cycle sweep request
//   dut_out    : gate-under-test output
//   stim       : gate-under-test input vector
//   busy, done : sweep status
//   pass, err_count, fail_seen, first_fail : sweep results
// master = controller/GUT side, slave = checker side.
interface gate_sweep_checker_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_seen;
  logic [N_IN-1:0] first_fail;

  modport master (
    output start, dut_out,
    input  stim, busy, done, pass, err_count, fail_seen, first_fail
  );

  modport slave (
    input  start, dut_out,
    output stim, busy, done, pass, err_count, fail_seen, first_fail
  );
endinterface

// File: rtl/gate_sweep_checker_settle_timer.sv
// Settle interval counter.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (priority over en_i)
//   en_i       : count up by one
//   tc_val_i   : terminal count value
//   tc_o       : high while the count equals tc_val_i
module settle_timer
  import gate_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table checker for a small combinational gate.
// Drives every input vector on bus.stim, holds it SETTLE_CYC cycles, samples
// bus.dut_out for one cycle and compares against EXP_TABLE[vector].
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of gate_sweep_checker_if (start/dut_out in,
//                stim/busy/done/pass/err_count/fail_seen/first_fail out)
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int                         N_IN       = 2,
  parameter logic [vec_count(N_IN)-1:0] EXP_TABLE  = 4'b1000,
  parameter int                         SETTLE_CYC = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_sweep_checker_if.slave bus
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || N_IN < 1 || N_IN > 4) begin : g_bad_param
    $fatal(1, "gate_sweep_checker: illegal N_IN or SETTLE_CYC");
  end

  localparam int              ERR_W    = N_IN + 1;
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fail_q, fail_d;
  logic [N_IN-1:0]   first_q, first_d;
  logic              pass_q, pass_d;
  logic              busy, done;
  logic              tc, mismatch;

  settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != SETTLE),
    .en_i     (state_q == SETTLE),
    .tc_val_i (CNT_W'(SETTLE_CYC - 1)),
    .tc_o     (tc)
  );

  assign mismatch = (bus.dut_out != EXP_TABLE[idx_q]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SETTLE;
      SETTLE:  if (tc) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == IDX_LAST) ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Result datapath. stim is idx_q directly, so it is registered and only
  // moves on SAMPLE->SETTLE, start acceptance, or the DONE->IDLE return.
  // pass is decided from the post-update count on the last SAMPLE so it is
  // already valid in the DONE cycle.
  always_comb begin
    idx_d   = idx_q;
    err_d   = err_q;
    fail_d  = fail_q;
    first_d = first_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          err_d   = '0;
          fail_d  = 1'b0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + ERR_W'(1);
          if (!fail_q) begin
            fail_d  = 1'b1;
            first_d = idx_q;
          end
        end
        if (idx_q == IDX_LAST) pass_d = (err_d == '0);
        else                   idx_d  = idx_q + N_IN'(1);
      end
      DONE:    idx_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.stim       = idx_q;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_seen  = fail_q;
  assign bus.first_fail = first_q;

endmodule
